pair_triple_stream_gen: RTL and testbench

- Transmit-side companion to the pair/triple detector. Generates a stream of symbols grouped into runs of 1, 2 or 3 identical values.
- Each symbol carries the flags a correct detector must raise on it, so a bench or on-chip self-test can compare the detector output directly against them.
- Sits between the control inputs and the detector's symbol input; the stream uses a valid/ready handshake.

---
 rtl/pt_pkg.sv | 41 ++++
 rtl/pt_lfsr.sv | 46 ++++
 rtl/pair_triple_stream_gen.sv | 161 ++++++++++++++++
 tb/tb_pair_triple_stream_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared definitions for the pair/triple stream generator and its detector:
// FSM state encoding, run-length mode codes, LFSR tap default and the
// symbol width both blocks agree on.
package pt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_FINISH = 2'd2
    } pt_state_e;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_PAIR   = 2'd1;
    localparam logic [1:0] MODE_TRIPLE = 2'd2;
    localparam logic [1:0] MODE_RANDOM = 2'd3;

    // Galois taps for the 8-bit LFSR (x^8 + x^6 + x^5 + x^4 + 1).
    localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;

    localparam int SYM_W_DEFAULT = 4;

    // Run length 1..3 for a run mode; t is the top two LFSR bits, used only
    // in random mode, where t=3 folds back onto length 1.
    function automatic logic [1:0] mode_run_len(input logic [1:0] mode,
                                                input logic [1:0] t);
        logic [1:0] len;
        len = 2'd1;
        if (mode == MODE_RANDOM) begin
            case (t)
                2'd0:    len = 2'd1;
                2'd1:    len = 2'd2;
                2'd2:    len = 2'd3;
                default: len = 2'd1;
            endcase
        end else begin
            len = mode + 2'd1;
        end
        return len;
    endfunction

endpackage

// File: rtl/pt_lfsr.sv
// Galois LFSR with seed load (a zero seed becomes 1) and step enable.
// "cur" is the value a run setup must use this cycle: the sanitised seed
// while loading, otherwise the stored state. The register always takes one
// step past whatever value was consumed.
module pt_lfsr
    import pt_pkg::*;
#(
    parameter int             W     = 8,
    parameter int             SYM_W = SYM_W_DEFAULT,
    parameter logic [W-1:0]   TAPS  = W'(LFSR_TAPS_8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     seed,
    output logic [SYM_W-1:0] sym_bits,
    output logic [1:0]       len_bits
);

    logic [W-1:0] q;
    logic [W-1:0] cur;
    logic [W-1:0] nxt;

    // Select the value seen by run setup and compute its successor.
    always_comb begin
        cur = q;
        if (load) begin
            cur = (seed == '0) ? W'(1) : seed;
        end
        nxt = {1'b0, cur[W-1:1]} ^ (cur[0] ? TAPS : '0);
    end

    assign sym_bits = cur[SYM_W-1:0];
    assign len_bits = cur[W-1 -: 2];

    // State register: resets to 1, advances on load or step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= W'(1);
        end else if (load || step) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/pair_triple_stream_gen.sv
// Burst generator of symbol runs of length 1..3 tagged with the flags a
// pair/triple detector should raise on each symbol.
//
// Handshake: a symbol transfers on a rising edge where sym_valid and
// sym_ready are both high. Once sym_valid rises it stays high, with sym,
// sym_last, exp_pair and exp_triple frozen, until that transfer happens.
module pair_triple_stream_gen
    import pt_pkg::*;
#(
    parameter int SYM_W  = SYM_W_DEFAULT,
    parameter int LFSR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_runs,
    input  logic [LFSR_W-1:0] seed,
    output logic [SYM_W-1:0]  sym,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic              sym_last,
    output logic              exp_pair,
    output logic              exp_triple,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    pt_state_e        state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] runs_left_q, runs_left_d;
    logic [1:0]       pos_q, pos_d;
    logic [1:0]       len_q, len_d;
    logic [SYM_W-1:0] sym_q, sym_d;

    logic             lfsr_load;
    logic             lfsr_step;
    logic [SYM_W-1:0] lfsr_sym;
    logic [1:0]       lfsr_len;

    logic [SYM_W-1:0] setup_sym;
    logic [1:0]       setup_len;
    logic [1:0]       setup_mode;
    logic             in_emit;
    logic             xfer;
    logic             run_end;
    logic             last_sym;

    pt_lfsr #(
        .W     (LFSR_W),
        .SYM_W (SYM_W)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .step     (lfsr_step),
        .seed     (seed),
        .sym_bits (lfsr_sym),
        .len_bits (lfsr_len)
    );

    // Run setup: the candidate symbol is bumped when it repeats the previous
    // run's symbol so runs never merge; run 0 (set up from IDLE) is exempt.
    always_comb begin
        setup_mode = (state_q == ST_IDLE) ? mode : mode_q;
        setup_sym  = lfsr_sym;
        if (state_q != ST_IDLE && lfsr_sym == sym_q) begin
            setup_sym = lfsr_sym + SYM_W'(1);
        end
        setup_len = mode_run_len(setup_mode, lfsr_len);
    end

    assign in_emit  = (state_q == ST_EMIT);
    assign xfer     = in_emit && sym_ready;
    assign run_end  = (pos_q == len_q);
    assign last_sym = run_end && (runs_left_q == CNT_W'(1));

    // Next-state logic: burst start, per-symbol advance and run setup.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        runs_left_d = runs_left_q;
        pos_d       = pos_q;
        len_d       = len_q;
        sym_d       = sym_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_runs != '0) begin
                        lfsr_load   = 1'b1;
                        mode_d      = mode;
                        runs_left_d = num_runs;
                        sym_d       = setup_sym;
                        len_d       = setup_len;
                        pos_d       = 2'd1;
                        state_d     = ST_EMIT;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (!run_end) begin
                        pos_d = pos_q + 2'd1;
                    end else if (last_sym) begin
                        state_d = ST_FINISH;
                    end else begin
                        lfsr_step   = 1'b1;
                        runs_left_d = runs_left_q - CNT_W'(1);
                        sym_d       = setup_sym;
                        len_d       = setup_len;
                        pos_d       = 2'd1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_SINGLE;
            runs_left_q <= '0;
            pos_q       <= '0;
            len_q       <= '0;
            sym_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            runs_left_q <= runs_left_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            sym_q       <= sym_d;
        end
    end

    // Outputs are forced to zero outside EMIT so idle and reset look alike.
    always_comb begin
        sym_valid  = in_emit;
        sym        = in_emit ? sym_q : '0;
        exp_pair   = in_emit && (pos_q == 2'd2);
        exp_triple = in_emit && (pos_q == 2'd3);
        sym_last   = in_emit && last_sym;
        busy       = in_emit;
        done       = (state_q == ST_FINISH);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_pair_triple_stream_gen.sv
// Self-checking bench for pair_triple_stream_gen: a behavioural model
// expands each burst into its expected symbol list, and a negedge monitor
// scores every transfer, stall hold, and done pulse against it.
module tb_pair_triple_stream_gen;

    localparam int SYM_W  = 4;
    localparam int LFSR_W = 8;
    localparam int CNT_W  = 8;
    localparam int EW     = SYM_W + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  num_runs;
    logic [LFSR_W-1:0] seed;
    logic [SYM_W-1:0]  sym;
    logic              sym_valid;
    logic              sym_ready;
    logic              sym_last;
    logic              exp_pair;
    logic              exp_triple;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    pair_triple_stream_gen #(
        .SYM_W  (SYM_W),
        .LFSR_W (LFSR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .num_runs   (num_runs),
        .seed       (seed),
        .sym        (sym),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_last   (sym_last),
        .exp_pair   (exp_pair),
        .exp_triple (exp_triple),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: {sym, pair, triple, last} per expected symbol.
    logic [EW-1:0]    exp_q[$];
    logic [SYM_W-1:0] obs_syms[$];

    // Reference model: walk the runs directly from the generation rules.
    task automatic build_model(input logic [7:0] seed_v, input logic [1:0] mode_v, input int runs);
        int s;
        int prev;
        int cand;
        int len;
        s = (seed_v == 8'd0) ? 1 : int'(seed_v);
        prev = -1;
        exp_q.delete();
        for (int r = 0; r < runs; r++) begin
            cand = s % 16;
            if (r > 0 && cand == prev) cand = (cand + 1) % 16;
            if (mode_v == 2'd3) begin
                case (s / 64)
                    0: len = 1;
                    1: len = 2;
                    2: len = 3;
                    default: len = 1;
                endcase
            end else begin
                len = int'(mode_v) + 1;
            end
            if (s % 2 == 1) s = (s / 2) ^ 'hB8;
            else s = s / 2;
            for (int p = 1; p <= len; p++) begin
                exp_q.push_back({4'(cand), p == 2, p == 3, (r == runs - 1) && (p == len)});
            end
            prev = cand;
        end
    endtask

    // Monitor
    logic             mon_stall = 1'b0;
    logic [EW:0]      held;
    logic             done_exp  = 1'b0;
    logic             done_seen = 1'b0;
    logic             have_prev = 1'b0;
    logic [SYM_W-1:0] prev_sym;
    logic [EW-1:0]    e;

    always @(negedge clk) begin
        if (rst) begin
            mon_stall = 1'b0;
            done_exp  = 1'b0;
            have_prev = 1'b0;
        end else begin
            check_val("busy_done_excl", busy & done, 0);
            check_val("done_pulse", done, done_exp);
            if (done) done_seen = 1'b1;
            done_exp = 1'b0;
            if (mon_stall) begin
                check_val("stall_hold", {sym_valid, sym, exp_pair, exp_triple, sym_last}, held);
            end
            if (sym_valid && sym_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_symbol", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("sym", sym, e[EW-1:3]);
                    check_val("exp_pair", exp_pair, e[2]);
                    check_val("exp_triple", exp_triple, e[1]);
                    check_val("sym_last", sym_last, e[0]);
                end
                if (!exp_pair && !exp_triple && have_prev) begin
                    check_val("adjacent_runs_differ", sym != prev_sym, 1);
                end
                prev_sym  = sym;
                have_prev = 1'b1;
                obs_syms.push_back(sym);
                if (sym_last) begin
                    done_exp  = 1'b1;
                    have_prev = 1'b0;
                end
            end
            mon_stall = sym_valid && !sym_ready;
            held      = {sym_valid, sym, exp_pair, exp_triple, sym_last};
        end
    end

    // Driver: one burst from start pulse to done, optionally poking inputs mid-burst.
    task automatic run_burst(input logic [7:0] seed_v, input logic [1:0] mode_v, input int runs,
                             input bit rnd_ready, input bit poke_start);
        int expected_n;
        int cyc;
        build_model(seed_v, mode_v, runs);
        expected_n = exp_q.size();
        obs_syms.delete();
        done_seen = 1'b0;
        have_prev = 1'b0;
        @(posedge clk);
        #1;
        seed      = seed_v;
        mode      = mode_v;
        num_runs  = CNT_W'(runs);
        start     = 1'b1;
        sym_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (runs == 0) done_exp = 1'b1;
        if (rnd_ready) sym_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_val("start_latency", sym_valid, (runs != 0) ? 1 : 0);
        cyc = 0;
        while (!done_seen && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rnd_ready) sym_ready = 1'($urandom_range(0, 1));
            if (poke_start && cyc >= 2 && cyc <= 10) begin
                start    = (cyc % 3 == 0);
                seed     = 8'($urandom);
                mode     = 2'($urandom);
                num_runs = 8'($urandom_range(1, 255));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!done_seen) check_val("burst_timeout", 0, 1);
        check_val("symbol_count", obs_syms.size(), expected_n);
        check_val("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_sym_valid"}, sym_valid, 0);
        check_val({tag, "_sym"}, sym, 0);
        check_val({tag, "_sym_last"}, sym_last, 0);
        check_val({tag, "_exp_pair"}, exp_pair, 0);
        check_val({tag, "_exp_triple"}, exp_triple, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
    endtask

    // Abort a burst with reset after four transfers, then replay the same seed.
    task automatic reset_mid_burst();
        logic [SYM_W-1:0] first4[4];
        int cyc;
        build_model(8'h33, 2'd3, 30);
        obs_syms.delete();
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        seed      = 8'h33;
        mode      = 2'd3;
        num_runs  = 8'd30;
        start     = 1'b1;
        sym_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (obs_syms.size() < 4 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_val("four_transfers_seen", obs_syms.size(), 4);
        for (int i = 0; i < 4; i++) first4[i] = obs_syms[i];
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        check_val("no_done_after_abort", done_seen, 0);
        run_burst(8'h33, 2'd3, 30, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_val("replay_sym", obs_syms[i], first4[i]);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        num_runs  = '0;
        seed      = '0;
        sym_ready = 1'b0;
        #1;
        check_outputs_zero("reset");
        check_val("reset_state", state_dbg, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pairs from seed 0x5A: A A D D E E.
        run_burst(8'h5A, 2'd1, 3, 1'b0, 1'b0);
        check_val("pair_sym1", obs_syms[0], 4'hA);
        check_val("pair_sym2", obs_syms[1], 4'hA);
        check_val("pair_sym3", obs_syms[2], 4'hD);
        check_val("pair_sym6", obs_syms[5], 4'hE);

        // Triples: runs must differ at the boundary.
        run_burst(8'h5A, 2'd2, 2, 1'b0, 1'b0);
        check_val("triple_sym1", obs_syms[0], 4'hA);
        check_val("triple_boundary", obs_syms[3] != obs_syms[2], 1);

        // Random lengths under random backpressure.
        run_burst(8'($urandom), 2'd3, 200, 1'b1, 1'b0);
        run_burst(8'($urandom), 2'd3, 40, 1'b1, 1'b0);

        // Empty burst.
        run_burst(8'h12, 2'd1, 0, 1'b0, 1'b0);

        // Singles, and a zero seed standing in for 1.
        run_burst(8'h00, 2'd0, 10, 1'b1, 1'b0);

        reset_mid_burst();

        // Start pulses and input churn while busy.
        run_burst(8'h77, 2'd3, 20, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
